// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: splits 32-bit MEM-stage loads/stores into two 16-bit SRAM accesses with programmable wait states.
// Optional address checking is enabled by defining SRAM_ADDR_CHECK_EN.
module sram_mem_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] ST_val,
  output logic        mem_freeze,
  output logic [31:0] Mem_read_value,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_wdata,
  input  logic [15:0] sram_rdata,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        addr_err
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] cnt;
  logic is_wr, req, addr_ok, last, busy, start;
  logic [17:0] base, base_q, addr_q;
  logic [15:0] wdata_q, rd_lo;
  logic [31:0] st_q;
  assign req = MEM_R_EN | MEM_W_EN;
  // (addr-1024)>>2 modulo 2^17 equals (addr>>2)-256 modulo 2^17
  assign base = {ALU_result[18:2] - 17'd256, 1'b0};
  assign last = cnt == WAIT_CYCLES[2:0];
  assign busy = state == LO || state == HI;
`ifdef SRAM_ADDR_CHECK_EN
  logic err_q;
  assign addr_ok = ALU_result >= 32'd1024 && ALU_result < 32'h0008_0400 && ALU_result[1:0] == 2'b00;
  assign addr_err = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (state == IDLE && req && !addr_ok) err_q <= 1'b1;
`else
  assign addr_ok = 1'b1;
  assign addr_err = 1'b0;
`endif
  assign start = state == IDLE && req && addr_ok;
  assign mem_freeze = start || busy;
  assign sram_we_n = !(busy && is_wr);
  assign sram_oe_n = !(busy && !is_wr);
  assign sram_addr = state == LO ? base_q : state == HI ? base_q + 18'd1 : addr_q;
  assign sram_wdata = state == LO ? st_q[15:0] : state == HI ? st_q[31:16] : wdata_q;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = start ? LO : IDLE;
    else if (state == DONE) state_nx = IDLE;
    else if (last) state_nx = state == LO ? HI : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_wr <= 1'b0;
      base_q <= '0;
      st_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_lo <= '0;
      Mem_read_value <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? 3'd0 : cnt + 3'd1;
      if (start) begin
        is_wr <= MEM_W_EN;
        base_q <= base;
        st_q <= ST_val;
      end
      if (busy) begin
        addr_q <= sram_addr;
        wdata_q <= sram_wdata;
      end
      if (!is_wr && state == LO && last) rd_lo <= sram_rdata;
      if (!is_wr && state == HI && last) Mem_read_value <= {sram_rdata, rd_lo};
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed checks of sram_mem_ctrl at WAIT_CYCLES=1 and WAIT_CYCLES=0 against simple SRAM models.
module tb_sram_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] alu_result = '0, st_val = '0;
  logic mem_freeze, we_n, oe_n, addr_err;
  logic [31:0] rv;
  logic [17:0] addr;
  logic [15:0] wdata, rdata;
  logic z_r = 1'b0, z_w = 1'b0;
  logic [31:0] z_alu = '0, z_st = '0;
  logic z_freeze, z_we_n, z_oe_n, z_err;
  logic [31:0] z_rv;
  logic [17:0] z_addr;
  logic [15:0] z_wdata, z_rdata;
  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  sram_mem_ctrl #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
    .ALU_result(alu_result), .ST_val(st_val), .mem_freeze(mem_freeze),
    .Mem_read_value(rv), .sram_addr(addr), .sram_wdata(wdata), .sram_rdata(rdata),
    .sram_we_n(we_n), .sram_oe_n(oe_n), .addr_err(addr_err));

  sram_mem_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .MEM_R_EN(z_r), .MEM_W_EN(z_w),
    .ALU_result(z_alu), .ST_val(z_st), .mem_freeze(z_freeze),
    .Mem_read_value(z_rv), .sram_addr(z_addr), .sram_wdata(z_wdata), .sram_rdata(z_rdata),
    .sram_we_n(z_we_n), .sram_oe_n(z_oe_n), .addr_err(z_err));

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0;
      mem0[i] = 16'h0;
    end
    mem1[2] = 16'hBEEF;
    mem1[3] = 16'hDEAD;
  end
  always @(posedge clk) if (!we_n) mem1[addr[7:0]] <= wdata;
  always @(posedge clk) if (!z_we_n) mem0[z_addr[7:0]] <= z_wdata;
  assign rdata = mem1[addr[7:0]];
  assign z_rdata = mem0[z_addr[7:0]];

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (mem_freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got=%b exp=0", mem_freeze); end
    checks++; if (we_n !== 1'b1 || oe_n !== 1'b1) begin errors++; $display("FAIL rst_strobes got=%b%b exp=11", we_n, oe_n); end
    checks++; if (addr !== 18'd0 || wdata !== 16'd0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=0/0", addr, wdata); end
    checks++; if (rv !== 32'd0 || addr_err !== 1'b0) begin errors++; $display("FAIL rst_rv_err got=%h/%b exp=0/0", rv, addr_err); end
    rst_n = 1'b1;
    cyc;
  endtask

  task automatic test_write;
    logic [17:0] ea;
    logic [15:0] ew;
    int fcnt;
    mem_w_en = 1'b1; alu_result = 32'd1024; st_val = 32'hDEADBEEF;
    #1;
    fcnt = mem_freeze ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      cyc;
      if (i == 0) begin mem_w_en = 1'b0; alu_result = '0; st_val = '0; end
      #1;
      ea = i < 2 ? 18'd0 : 18'd1;
      ew = i < 2 ? 16'hBEEF : 16'hDEAD;
      if (mem_freeze) fcnt++;
      checks++; if (we_n !== 1'b0 || oe_n !== 1'b1) begin errors++; $display("FAIL wr_strobes c%0d got=%b%b exp=01", i, we_n, oe_n); end
      checks++; if (addr !== ea || wdata !== ew) begin errors++; $display("FAIL wr_bus c%0d got=%h/%h exp=%h/%h", i, addr, wdata, ea, ew); end
    end
    cyc;
    checks++; if (fcnt != 5 || mem_freeze !== 1'b0) begin errors++; $display("FAIL wr_freeze got=%0d/%b exp=5/0", fcnt, mem_freeze); end
    checks++; if (we_n !== 1'b1 || addr !== 18'd1 || wdata !== 16'hDEAD) begin errors++; $display("FAIL wr_done_hold got=%b/%h/%h exp=1/1/dead", we_n, addr, wdata); end
    checks++; if (mem1[0] !== 16'hBEEF || mem1[1] !== 16'hDEAD) begin errors++; $display("FAIL wr_sram got=%h/%h exp=beef/dead", mem1[0], mem1[1]); end
    cyc;
  endtask

  task automatic test_read;
    logic [17:0] ea;
    mem_r_en = 1'b1; alu_result = 32'd1028;
    #1;
    checks++; if (mem_freeze !== 1'b1) begin errors++; $display("FAIL rd_freeze_idle got=%b exp=1", mem_freeze); end
    for (int i = 0; i < 4; i++) begin
      cyc;
      ea = i < 2 ? 18'd2 : 18'd3;
      checks++; if (mem_freeze !== 1'b1 || oe_n !== 1'b0 || we_n !== 1'b1 || addr !== ea)
        begin errors++; $display("FAIL rd_cycle c%0d got=%b%b%b/%h exp=101/%h", i, mem_freeze, oe_n, we_n, addr, ea); end
    end
    cyc;
    checks++; if (mem_freeze !== 1'b0) begin errors++; $display("FAIL rd_freeze_6th got=%b exp=0", mem_freeze); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_value got=%h exp=deadbeef", rv); end
    mem_r_en = 1'b0;
    cyc;
  endtask

  task automatic test_both;
    int wc = 0, oc = 0;
    mem_r_en = 1'b1; mem_w_en = 1'b1; alu_result = 32'd1032; st_val = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      cyc;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      #1;
      if (!we_n) wc++;
      if (!oe_n) oc++;
    end
    cyc;
    checks++; if (wc != 4 || oc != 0) begin errors++; $display("FAIL both_strobes got=%0d/%0d exp=4/0", wc, oc); end
    checks++; if (mem1[4] !== 16'h5678 || mem1[5] !== 16'h1234) begin errors++; $display("FAIL both_sram got=%h/%h exp=5678/1234", mem1[4], mem1[5]); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL both_rv got=%h exp=deadbeef", rv); end
    cyc;
  endtask

  task automatic test_reset_mid;
    int n;
    mem_w_en = 1'b1; alu_result = 32'd1036; st_val = 32'hA5A55A5A;
    cyc;
    mem_w_en = 1'b0;
    cyc;
    cyc;
    #1;
    checks++; if (we_n !== 1'b0 || addr !== 18'd7) begin errors++; $display("FAIL rm_in_hi got=%b/%h exp=0/7", we_n, addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (we_n !== 1'b1 || oe_n !== 1'b1 || mem_freeze !== 1'b0) begin errors++; $display("FAIL rm_strobes got=%b%b%b exp=110", we_n, oe_n, mem_freeze); end
    checks++; if (addr !== 18'd0 || wdata !== 16'd0 || rv !== 32'd0) begin errors++; $display("FAIL rm_regs got=%h/%h/%h exp=0/0/0", addr, wdata, rv); end
    #2;
    rst_n = 1'b1;
    cyc;
    mem_r_en = 1'b1; alu_result = 32'd1028;
    n = 0;
    do begin cyc; n++; end while (mem_freeze && n < 20);
    checks++; if (mem_freeze !== 1'b0 || n != 5) begin errors++; $display("FAIL rm_read_lat got=%0d exp=5", n); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_read_val got=%h exp=deadbeef", rv); end
    mem_r_en = 1'b0;
    cyc;
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat = 8'h77;
    int wc = 0, oc = 0;
    z_w = 1'b1; z_alu = 32'd1040; z_st = 32'hCAFEF00D;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin z_w = 1'b0; z_r = 1'b1; end
      #1;
      if (!z_we_n) wc++;
      if (!z_oe_n) oc++;
      checks++; if (z_freeze !== pat[k]) begin errors++; $display("FAIL b2b_freeze c%0d got=%b exp=%b", k, z_freeze, pat[k]); end
      if (k < 7) cyc;
    end
    checks++; if (z_rv !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rv got=%h exp=cafef00d", z_rv); end
    checks++; if (wc != 2 || oc != 2) begin errors++; $display("FAIL b2b_accesses got=%0d/%0d exp=2/2", wc, oc); end
    checks++; if (mem0[8] !== 16'hF00D || mem0[9] !== 16'hCAFE) begin errors++; $display("FAIL b2b_sram got=%h/%h exp=f00d/cafe", mem0[8], mem0[9]); end
    z_r = 1'b0;
    cyc;
    cyc;
    checks++; if (wc != 2 || z_freeze !== 1'b0) begin errors++; $display("FAIL b2b_no_restart got=%0d/%b exp=2/0", wc, z_freeze); end
  endtask

  task automatic test_addr_check;
`ifdef SRAM_ADDR_CHECK_EN
    int bad = 0;
    mem_r_en = 1'b1; alu_result = 32'd1000;
    #1;
    checks++; if (mem_freeze !== 1'b0) begin errors++; $display("FAIL ac_freeze got=%b exp=0", mem_freeze); end
    for (int i = 0; i < 4; i++) begin
      cyc;
      #1;
      if (mem_freeze || !oe_n || !we_n) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ac_no_access got=%0d exp=0", bad); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ac_err got=%b exp=1", addr_err); end
    checks++; if (rv !== 32'hDEADBEEF) begin errors++; $display("FAIL ac_rv got=%h exp=deadbeef", rv); end
    mem_r_en = 1'b0; mem_w_en = 1'b1; alu_result = 32'd1030;
    #1;
    checks++; if (mem_freeze !== 1'b0) begin errors++; $display("FAIL ac_unaligned got=%b exp=0", mem_freeze); end
    mem_w_en = 1'b0;
    cyc;
`else
    int n;
    mem_r_en = 1'b1; alu_result = 32'd1030;
    #1;
    checks++; if (mem_freeze !== 1'b1 || addr_err !== 1'b0) begin errors++; $display("FAIL nc_start got=%b/%b exp=1/0", mem_freeze, addr_err); end
    cyc;
    checks++; if (addr !== 18'd2 || oe_n !== 1'b0) begin errors++; $display("FAIL nc_addr got=%h/%b exp=2/0", addr, oe_n); end
    n = 1;
    while (mem_freeze && n < 20) begin cyc; n++; end
    checks++; if (mem_freeze !== 1'b0 || rv !== 32'hDEADBEEF || addr_err !== 1'b0) begin errors++; $display("FAIL nc_done got=%b/%h/%b exp=0/deadbeef/0", mem_freeze, rv, addr_err); end
    mem_r_en = 1'b0;
    cyc;
`endif
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_both;
    test_reset_mid;
    test_back_to_back;
    test_addr_check;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
